axis_accum_bcd: RTL and testbench

- AXI-Stream accumulator, successor to the fixed-N count/sum block.
- Sums unsigned input beats until N beats have been accepted or a beat arrives with s_last, whichever comes first.
- Converts the frame sum to NDIG decimal digits with a sequential double-dabble engine and drives 7-segment codes.
- Presents {sum, count, segments, overflow} as one output beat on a ready/valid master port; sits between a sample source and a display/reporting sink.

---
 rtl/axis_accum_bcd.sv | 194 +++++++++++++++++++
 tb/tb_axis_accum_bcd.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_accum_bcd.sv
// axis_accum_bcd: AXI-Stream frame accumulator with a BCD / 7-segment result.
// Sums unsigned beats until N beats arrive or a beat carries s_last. The
// frame sum is then converted to NDIG decimal digits by a serial
// double-dabble engine, one bit per clock. The result is presented as a
// single beat on a ready/valid master port.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_ACCUM   | accepting input beats, accumulating sum and count
// ST_CONVERT | frame closed, SW shift-add-3 iterations in progress
// ST_OUTPUT  | result valid on m_*, waiting for m_ready
module axis_accum_bcd #(
  parameter int unsigned W              = 3,
  parameter int unsigned N              = 5,
  parameter int unsigned NDIG           = 2,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  localparam int unsigned CW            = $clog2(N + 1),
  localparam int unsigned SW            = W + CW
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [W-1:0]        s_data,
  input  logic                s_last,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [SW-1:0]       m_sum,
  output logic [CW-1:0]       m_count,
  output logic [NDIG*7-1:0]   m_seg,
  output logic                m_overflow
);

  localparam logic [1:0] ST_ACCUM   = 2'd0;
  localparam logic [1:0] ST_CONVERT = 2'd1;
  localparam logic [1:0] ST_OUTPUT  = 2'd2;

  // Iteration counter must be able to hold SW itself.
  localparam int unsigned IW = $clog2(SW + 1);
  localparam int unsigned BW = 4 * NDIG;

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  // Largest value displayable in NDIG digits; valid for NDIG up to 19.
  localparam logic [63:0] DEC_MAX = pow10(NDIG) - 64'd1;

  localparam logic [6:0] SEG_DASH = 7'h40;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] sum_q,   sum_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [IW-1:0] iter_q,  iter_d;
  logic [SW-1:0] bin_q,   bin_d;
  logic [BW-1:0] bcd_q,   bcd_d;

  logic          hs_in;
  logic          frame_end;
  logic [SW-1:0] sum_inc;
  logic [CW-1:0] cnt_inc;
  logic [BW-1:0] bcd_adj;
  logic [BW-1:0] bcd_step;
  logic [SW-1:0] bin_step;
  logic [NDIG*7-1:0] seg_raw;

  assign s_ready = (state_q == ST_ACCUM);
  assign m_valid = (state_q == ST_OUTPUT);

  assign hs_in     = s_valid & s_ready;
  assign sum_inc   = sum_q + {{CW{1'b0}}, s_data};
  assign cnt_inc   = cnt_q + CW'(1);
  assign frame_end = hs_in & ((cnt_inc == CW'(N)) | s_last);

  // Double-dabble: add 3 to every digit >= 5, then shift {bcd, bin} left.
  // Digits above NDIG are dropped; the low digits stay exact and
  // overflow is flagged separately from the binary sum.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign bcd_step = {bcd_adj[BW-2:0], bin_q[SW-1]};
  assign bin_step = {bin_q[SW-2:0], 1'b0};

  // Next-state logic for the frame FSM and its datapath.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    iter_d  = iter_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    case (state_q)
      ST_ACCUM: begin
        if (hs_in) begin
          sum_d = sum_inc;
          cnt_d = cnt_inc;
          if (frame_end) begin
            state_d = ST_CONVERT;
            bin_d   = sum_inc;
            bcd_d   = '0;
            iter_d  = IW'(SW);
          end
        end
      end
      ST_CONVERT: begin
        bin_d  = bin_step;
        bcd_d  = bcd_step;
        iter_d = iter_q - IW'(1);
        if (iter_q == IW'(1)) begin
          state_d = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        // s_ready only returns after this edge: no same-cycle bypass.
        if (m_ready) begin
          state_d = ST_ACCUM;
          sum_d   = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_ACCUM;
        sum_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers; reset drops any partial frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_ACCUM;
      sum_q   <= '0;
      cnt_q   <= '0;
      iter_q  <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      iter_q  <= iter_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
    end
  end

  // Result fields are exposed only while the beat is valid, zero otherwise.
  assign m_sum      = m_valid ? sum_q : '0;
  assign m_count    = m_valid ? cnt_q : '0;
  assign m_overflow = m_valid & (64'(sum_q) > DEC_MAX);

  // Segment encoding: blank when idle, dashes on overflow, digits otherwise.
  always_comb begin
    seg_raw = '0;
    if (m_valid) begin
      for (int i = 0; i < int'(NDIG); i++) begin
        seg_raw[7*i +: 7] = m_overflow ? SEG_DASH : seg_code(bcd_q[4*i +: 4]);
      end
    end
  end

  assign m_seg = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;

endmodule

// File: tb/tb_axis_accum_bcd.sv
// Testbench for axis_accum_bcd: three instances (default, NDIG=1,
// NDIG=1 active-low) share one stimulus stream. A frame-level model
// checks every cycle, and literal expectations pin the model.
module tb_axis_accum_bcd;
  localparam int W  = 3;
  localparam int N  = 5;
  localparam int CW = 3;
  localparam int SW = 6;

  localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic clk = 1'b0;
  logic rstn, s_valid, s_last, m_ready;
  logic [W-1:0] s_data;

  logic s_ready, m_valid, m_overflow;
  logic [SW-1:0] m_sum;
  logic [CW-1:0] m_count;
  logic [13:0] m_seg;

  logic sr_a, mv_a, ovf_a;
  logic [SW-1:0] sum_a;
  logic [CW-1:0] cnt_a;
  logic [6:0] seg_a;

  logic sr_b, mv_b, ovf_b;
  logic [SW-1:0] sum_b;
  logic [CW-1:0] cnt_b;
  logic [6:0] seg_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_acc = 0;

  axis_accum_bcd u_dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
    .m_sum(m_sum), .m_count(m_count), .m_seg(m_seg), .m_overflow(m_overflow));

  axis_accum_bcd #(.NDIG(1)) u_dut_n1 (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(sr_a),
    .s_data(s_data), .s_last(s_last), .m_valid(mv_a), .m_ready(m_ready),
    .m_sum(sum_a), .m_count(cnt_a), .m_seg(seg_a), .m_overflow(ovf_a));

  axis_accum_bcd #(.NDIG(1), .SEG_ACTIVE_LOW(1'b1)) u_dut_n1al (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(sr_b),
    .s_data(s_data), .s_last(s_last), .m_valid(mv_b), .m_ready(m_ready),
    .m_sum(sum_b), .m_count(cnt_b), .m_seg(seg_b), .m_overflow(ovf_b));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Expected segment word straight from the decimal value of the sum.
  function automatic logic [13:0] exp_seg(input int sum, input int ndig, input bit al);
    logic [13:0] r;
    int lim;
    int p;
    r = '0;
    lim = 1;
    for (int i = 0; i < ndig; i++) lim = lim * 10;
    p = 1;
    for (int i = 0; i < ndig; i++) begin
      r[7*i +: 7] = (sum > lim - 1) ? 7'h40 : SEG_TAB[(sum / p) % 10];
      p = p * 10;
    end
    if (al) begin
      for (int i = 0; i < 7 * ndig; i++) r[i] = ~r[i];
    end
    return r;
  endfunction

  // Frame-level model: beats collected in a queue, result due SW edges
  // after the closing beat, held until taken.
  initial begin : model
    int frame_q[$];
    bit done;
    int wait_c;
    int e_sum;
    int e_cnt;
    done = 1'b0;
    wait_c = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        check("rst_m_valid", 64'(m_valid), 64'(0));
        check("rst_m_valid_n1", 64'(mv_a | mv_b), 64'(0));
        frame_q.delete();
        done = 1'b0;
        wait_c = 0;
      end else begin
        check("s_ready", 64'(s_ready), 64'(!done));
        check("s_ready_n1", 64'({sr_a, sr_b}), 64'({!done, !done}));
        check("m_valid", 64'(m_valid), 64'(done && wait_c == 0));
        check("m_valid_n1", 64'({mv_a, mv_b}), 64'({2{done && wait_c == 0}}));
        if (done && wait_c == 0) begin
          e_sum = 0;
          foreach (frame_q[i]) e_sum += frame_q[i];
          e_cnt = frame_q.size();
          check("m_sum", 64'(m_sum), 64'(e_sum));
          check("m_count", 64'(m_count), 64'(e_cnt));
          check("m_seg", 64'(m_seg), 64'(exp_seg(e_sum, 2, 1'b0)));
          check("m_overflow", 64'(m_overflow), 64'(e_sum > 99));
          check("n1_sum_count", 64'({sum_a, cnt_a, sum_b, cnt_b}),
                64'({SW'(e_sum), CW'(e_cnt), SW'(e_sum), CW'(e_cnt)}));
          check("n1_seg", 64'(seg_a), 64'(exp_seg(e_sum, 1, 1'b0)));
          check("n1al_seg", 64'(seg_b), 64'(exp_seg(e_sum, 1, 1'b1)));
          check("n1_overflow", 64'({ovf_a, ovf_b}), 64'({2{e_sum > 9}}));
        end
        if (done) begin
          if (wait_c > 0) wait_c--;
          else if (m_ready) begin
            frame_q.delete();
            done = 1'b0;
          end
        end else if (s_valid) begin
          frame_q.push_back(int'(s_data));
          if (frame_q.size() == N || s_last) begin
            done = 1'b1;
            wait_c = SW;
          end
        end
      end
    end
  end

  task automatic send(input int d, input bit l);
    bit ok;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data = W'(d);
    s_last = l;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
    end
    check("send_accept", 64'(ok), 64'(1));
    last_acc = cyc;
  endtask

  task automatic wait_valid(input int lat, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (m_valid) seen = 1'b1;
    end
    check({tag, "_valid_seen"}, 64'(seen), 64'(1));
    if (seen) check({tag, "_latency"}, 64'(cyc - last_acc), 64'(lat));
  endtask

  task automatic pop_out();
    @(posedge clk); #1;
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
  endtask

  initial begin : stim
    rstn = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sum", 64'(m_sum), 64'(0));
    check("rst_count", 64'(m_count), 64'(0));
    check("rst_seg", 64'(m_seg), 64'(0));
    check("rst_ovf", 64'(m_overflow), 64'(0));
    check("rst_seg_al", 64'(seg_b), 64'(7'h7F));
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 64'(s_ready), 64'(1));
    @(posedge clk); #1;

    // Frame A: 3,4,5,2,6 back to back, m_ready already high beforehand.
    m_ready = 1'b1;
    send(3, 0); send(4, 0); send(5, 0); send(2, 0); send(6, 0);
    s_valid = 1'b0;
    wait_valid(6, "A");
    check("A_sum", 64'(m_sum), 64'(20));
    check("A_count", 64'(m_count), 64'(5));
    check("A_seg0", 64'(m_seg[6:0]), 64'(7'h3F));
    check("A_seg1", 64'(m_seg[13:7]), 64'(7'h5B));
    check("A_ovf", 64'(m_overflow), 64'(0));
    check("A_n1_ovf", 64'(ovf_a), 64'(1));
    check("A_n1_seg", 64'(seg_a), 64'(7'h40));
    check("A_n1al_seg", 64'(seg_b), 64'(7'h3F));
    @(posedge clk); #1;
    m_ready = 1'b0;

    // Frame B: 7, 7+last.
    send(7, 0); send(7, 1);
    s_valid = 1'b0;
    wait_valid(6, "B");
    check("B_sum", 64'(m_sum), 64'(14));
    check("B_count", 64'(m_count), 64'(2));
    check("B_seg0", 64'(m_seg[6:0]), 64'(7'h66));
    check("B_seg1", 64'(m_seg[13:7]), 64'(7'h06));
    pop_out();

    // Frame C: five 7s, then hold m_ready low with extra beats offered.
    for (int i = 0; i < 5; i++) send(7, 0);
    s_data = 3'd1;
    wait_valid(6, "C");
    check("C_sum", 64'(m_sum), 64'(35));
    check("C_count", 64'(m_count), 64'(5));
    check("C_seg0", 64'(m_seg[6:0]), 64'(7'h6D));
    check("C_seg1", 64'(m_seg[13:7]), 64'(7'h4F));
    repeat (10) @(posedge clk);
    #1;
    @(negedge clk);
    check("hold_sum", 64'(m_sum), 64'(35));
    check("hold_ready", 64'(s_ready), 64'(0));
    @(posedge clk); #1;
    m_ready = 1'b1;
    s_valid = 1'b0;
    @(posedge clk); #1;
    m_ready = 1'b0;
    @(negedge clk);
    check("release_ready", 64'(s_ready), 64'(1));
    check("release_valid", 64'(m_valid), 64'(0));
    @(posedge clk); #1;

    // Frame D: s_last on the first beat.
    send(6, 1);
    s_valid = 1'b0;
    wait_valid(6, "D");
    check("D_count", 64'(m_count), 64'(1));
    check("D_seg", 64'(m_seg), 64'({7'h3F, 7'h7D}));
    check("D_n1al_seg", 64'(seg_b), 64'(7'h02));
    pop_out();

    // Frame E: s_last coincides with the Nth beat.
    send(1, 0); send(2, 0); send(3, 0); send(4, 0); send(5, 1);
    s_valid = 1'b0;
    wait_valid(6, "E");
    check("E_sum", 64'(m_sum), 64'(15));
    check("E_seg", 64'(m_seg), 64'({7'h06, 7'h6D}));
    pop_out();

    // Frame F: idle gaps between beats.
    send(0, 0);
    s_valid = 1'b0;
    @(posedge clk); #1;
    send(7, 0);
    s_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    send(0, 1);
    s_valid = 1'b0;
    wait_valid(6, "F");
    check("F_sum_count", 64'({m_sum, m_count}), 64'({6'd7, 3'd3}));
    check("F_seg", 64'(m_seg), 64'({7'h3F, 7'h07}));
    check("F_n1al_seg", 64'(seg_b), 64'(7'h78));
    pop_out();

    // Reset while converting: the frame must vanish.
    send(5, 0); send(5, 1);
    s_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rstn = 1'b0;
    @(negedge clk);
    check("midrst_valid", 64'(m_valid), 64'(0));
    check("midrst_sum", 64'(m_sum), 64'(0));
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check("midrst_ready", 64'(s_ready), 64'(1));
    @(posedge clk); #1;

    // Frame G: clean frame after reset.
    for (int i = 0; i < 5; i++) send(1, 0);
    s_valid = 1'b0;
    wait_valid(6, "G");
    check("G_sum", 64'(m_sum), 64'(5));
    check("G_seg", 64'(m_seg), 64'({7'h3F, 7'h6D}));
    pop_out();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout want finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule
